// File: rtl/pipelined_mem_responder_pkg.sv
// Shared WISC datapath types for the multi-cycle memory responder.
// Word/address widths, default latency and the pipeline stage bundle.
package wisc_pkg;

  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_DEPTH_W = 13;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/pipelined_mem_responder_if.sv
// Request/response bundle between the CPU (master) and memory (slave).
// Ports: enable, wr, addr, data_in -> memory; data_out, data_valid, addr_out <- memory.
interface pipelined_mem_responder_if;
  import wisc_pkg::*;

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, addr_out
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, addr_out
  );

endinterface

// File: rtl/pipelined_mem_responder_pipe.sv
// LATENCY-deep response shift register of {valid, addr, data}.
// Ports: clk, rst (async high), i_req (stage-1 input), o_resp (last stage).
module mem_resp_pipe
  import wisc_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic      clk,
  input  logic      rst,
  input  mem_resp_t i_req,
  output mem_resp_t o_resp
);

  mem_resp_t r_stage [LATENCY];

  // Valid always shifts; addr/data load only behind a valid entry so
  // the last stage holds the previous response across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++)
        r_stage[i] <= '0;
    end else begin
      r_stage[0].valid <= i_req.valid;
      if (i_req.valid) begin
        r_stage[0].addr <= i_req.addr;
        r_stage[0].data <= i_req.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i].valid <= r_stage[i-1].valid;
        if (r_stage[i-1].valid) begin
          r_stage[i].addr <= r_stage[i-1].addr;
          r_stage[i].data <= r_stage[i-1].data;
        end
      end
    end
  end

  assign o_resp = r_stage[LATENCY-1];

endmodule

// File: rtl/pipelined_mem_responder.sv
// Fixed-latency 16-bit memory target: writes land immediately, reads
// return LATENCY cycles later with an echoed address. Ports: clk, rst, bus.
module pipelined_mem_responder
  import wisc_pkg::*;
#(
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  pipelined_mem_responder_if.slave  bus
);

  localparam int WORDS = 2 ** DEPTH_W;

  logic [WORD_W-1:0]  r_mem [WORDS];
  logic [DEPTH_W-1:0] w_idx;
  logic               w_wr;
  mem_resp_t          w_req;
  mem_resp_t          w_resp;

  // addr[0] and bits above DEPTH_W are dropped, giving byte aliasing.
  assign w_idx = bus.addr[DEPTH_W:1];
  assign w_wr  = bus.enable && bus.wr && !rst;

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[w_idx] <= bus.data_in;
  end

  // Read data is captured at acceptance; later writes cannot alter it.
  always_comb begin
    w_req       = '0;
    w_req.valid = bus.enable && !bus.wr;
    w_req.addr  = bus.addr;
    w_req.data  = r_mem[w_idx];
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_req  (w_req),
    .o_resp (w_resp)
  );

  assign bus.data_valid = w_resp.valid;
  assign bus.data_out   = w_resp.data;
  assign bus.addr_out   = w_resp.addr;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Self-checking bench: random and directed traffic against a
// queue-based model of the fixed-latency responder.
module tb_pipelined_mem_responder;

  localparam int LAT = 4;
  localparam int DW  = 13;
  localparam int MSK = (1 << DW) - 1;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  pipelined_mem_responder_if bus ();

  pipelined_mem_responder #(
    .DEPTH_W (DW),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  int          cnt    = 0;
  logic [15:0] mdl [int];
  exp_t        exp_q [$];
  logic [15:0] seen [$];
  logic [15:0] last_d = '0;
  logic [15:0] last_a = '0;
  logic [15:0] wlist [$];

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    exp_t r;
    if (exp_q.size() != 0 && exp_q[0].due == cnt) begin
      r = exp_q.pop_front();
      chk("valid_hi", {15'd0, bus.data_valid}, 16'd1);
      chk("data", bus.data_out, r.data);
      chk("addr", bus.addr_out, r.addr);
      last_d = r.data;
      last_a = r.addr;
      seen.push_back(bus.data_out);
    end else begin
      chk("valid_lo", {15'd0, bus.data_valid}, 16'd0);
      chk("data_hold", bus.data_out, last_d);
      chk("addr_hold", bus.addr_out, last_a);
    end
  endtask

  // Called at a negedge; applies one request over the next rising edge.
  task automatic cyc(input logic en, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    int   idx;
    exp_t e;
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    cnt++;
    idx = (int'(a) >> 1) & MSK;
    if (en && w) mdl[idx] = d;
    if (en && !w) begin
      e.due  = cnt + LAT - 1;
      e.addr = a;
      e.data = mdl.exists(idx) ? mdl[idx] : 16'hxxxx;
      exp_q.push_back(e);
    end
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", {15'd0, bus.data_valid}, 16'd0);
    chk("rst_data", bus.data_out, 16'h0000);
    chk("rst_addr", bus.addr_out, 16'h0000);
    exp_q.delete();
    last_d = '0;
    last_a = '0;
    @(posedge clk);
    cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] a, d, r;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk("por_valid", {15'd0, bus.data_valid}, 16'd0);
    chk("por_data", bus.data_out, 16'h0000);
    rst = 1'b0;

    // Random traffic: only read words that have been written.
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      cyc(1'b1, 1'b1, a, 16'($urandom));
      wlist.push_back(a);
    end
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      a = wlist[$urandom_range(0, wlist.size() - 1)];
      case (r[1:0])
        2'd0: idle(1);
        2'd1: begin
          cyc(1'b1, 1'b1, a, 16'($urandom));
        end
        default: begin
          a = {a[15:14] ^ r[4:3], a[13:1], r[5]};
          cyc(1'b1, 1'b0, a, 16'($urandom));
        end
      endcase
    end
    idle(LAT + 1);

    // Reset then idle
    do_reset();
    idle(10);

    // Write then read
    seen.delete();
    cyc(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(LAT + 1);
    chk("wr_rd_cnt", 16'(seen.size()), 16'd1);
    if (seen.size() > 0) chk("wr_rd", seen[0], 16'hBEEF);

    // Back-to-back reads
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 1'b1, 16'(2 * i), 16'(i));
    seen.delete();
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 1'b0, 16'(2 * i), 16'h0);
    idle(LAT + 1);
    chk("b2b_cnt", 16'(seen.size()), 16'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk("b2b", seen[i], 16'(i + 1));

    // Write behind in-flight read
    cyc(1'b1, 1'b1, 16'h0020, 16'h1111);
    seen.delete();
    cyc(1'b1, 1'b0, 16'h0020, 16'h0);
    cyc(1'b1, 1'b1, 16'h0020, 16'h2222);
    cyc(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(LAT + 1);
    chk("wbehind_cnt", 16'(seen.size()), 16'd2);
    if (seen.size() > 1) begin
      chk("wbehind_old", seen[0], 16'h1111);
      chk("wbehind_new", seen[1], 16'h2222);
    end

    // Reset mid-flight
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 16'(16'h0030 + 2 * i), 16'(16'hC0 + i));
    seen.delete();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 16'(16'h0030 + 2 * i), 16'h0);
    do_reset();
    idle(LAT + 2);
    chk("midrst_none", 16'(seen.size()), 16'd0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 16'(16'h0030 + 2 * i), 16'h0);
    idle(LAT + 1);
    chk("midrst_cnt", 16'(seen.size()), 16'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      chk("midrst_keep", seen[i], 16'(16'hC0 + i));

    // Aliasing and addr[0]
    cyc(1'b1, 1'b1, 16'h0005, 16'hA5A5);
    seen.delete();
    cyc(1'b1, 1'b0, 16'h0004, 16'h0);
    cyc(1'b1, 1'b0, 16'h4004, 16'h0);
    idle(LAT + 1);
    chk("alias_cnt", 16'(seen.size()), 16'd2);
    if (seen.size() > 1) begin
      chk("alias_lo", seen[0], 16'hA5A5);
      chk("alias_hi", seen[1], 16'hA5A5);
    end
    chk("alias_addr", bus.addr_out, 16'h4004);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
